// File: rtl/fb_mdu_ctrl_pkg.sv
// rtl/fb_mdu_ctrl_pkg.sv - shared op indices, state encoding and helpers for the RV32M sequencer
package fb_mdu_ctrl_pkg;

    localparam int MDU_XLEN = 32;
    localparam int MDU_ITER = 32;

    // Bit positions inside the one-hot mdu_op vector (ALU control bits [18:11]).
    localparam int OP_MUL    = 7;
    localparam int OP_MULH   = 6;
    localparam int OP_MULHSU = 5;
    localparam int OP_MULHU  = 4;
    localparam int OP_DIV    = 3;
    localparam int OP_DIVU   = 2;
    localparam int OP_REM    = 1;
    localparam int OP_REMU   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/fb_mdu_step.sv
// rtl/fb_mdu_step.sv - one combinational shift-add multiply or restoring-divide iteration
module fb_mdu_step
#(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            keep;

    always_comb begin
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        rem_sh = {hi_i, lo_i[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
        // A kept difference is always below the divisor, so both top bits are zero.
        keep   = (diff[XLEN+1:XLEN] == 2'b00);

        if (is_div_i) begin
            hi_o = keep ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], keep};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/fb_mdu_ctrl.sv
// rtl/fb_mdu_ctrl.sv - iterative RV32M multiply/divide sequencer with pipeline stall
module fb_mdu_ctrl
    import fb_mdu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            op_valid_i,
    input  logic [7:0]      mdu_op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [7:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              op_ok;
    logic              in_is_div;
    logic              s1_signed;
    logic              s2_signed;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              div_by_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_val;

    fb_mdu_step #(.XLEN(XLEN)) u_step (
        .is_div_i (|op_q[3:0]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        op_ok       = is_onehot8(mdu_op_i);
        in_is_div   = |mdu_op_i[3:0];
        s1_signed   = mdu_op_i[OP_MULH] | mdu_op_i[OP_MULHSU] | mdu_op_i[OP_DIV] | mdu_op_i[OP_REM];
        s2_signed   = mdu_op_i[OP_MULH] | mdu_op_i[OP_DIV] | mdu_op_i[OP_REM];
        mag1        = (s1_signed && src1_i[XLEN-1]) ? (~src1_i + 1'b1) : src1_i;
        mag2        = (s2_signed && src2_i[XLEN-1]) ? (~src2_i + 1'b1) : src2_i;
        div_by_zero = in_is_div && (src2_i == '0);
        div_ovf     = (mdu_op_i[OP_DIV] | mdu_op_i[OP_REM])
                      && (src1_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (src2_i == {XLEN{1'b1}});
    end

    // Operands were iterated as magnitudes; restore the sign of the final value here.
    always_comb begin
        prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quot_fix = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = negr_q ? (~hi_q + 1'b1) : hi_q;
        if (|op_q[7:4]) begin
            fix_val = op_q[OP_MUL] ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[OP_DIV] | op_q[OP_DIVU]) begin
            fix_val = quot_fix;
        end else begin
            fix_val = rem_fix;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid_i && op_ok) begin
                        op_d   = mdu_op_i;
                        neg_d  = (s1_signed & src1_i[XLEN-1]) ^ (s2_signed & src2_i[XLEN-1]);
                        negr_d = s1_signed & src1_i[XLEN-1];
                        cnt_d  = '0;
                        hi_d   = '0;
                        lo_d   = in_is_div ? mag1 : mag2;
                        opnd_d = in_is_div ? mag2 : mag1;
                        if (div_by_zero) begin
                            result_d = (mdu_op_i[OP_DIV] | mdu_op_i[OP_DIVU]) ? {XLEN{1'b1}} : src1_i;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = mdu_op_i[OP_DIV] ? src1_i : '0;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MDU_ITER - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_d = fix_val;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign stall_o        = rst_ni & op_valid_i & (state_q != ST_DONE) & op_ok;
    assign result_valid_o = (state_q == ST_DONE) & ~flush_i;
    assign result_o       = result_q;

endmodule
